// File: rtl/mult4u_acc_stage.sv
// mult4u_acc_stage: sums windows of up to ACC_LEN 8-bit products from the
// 4-bit unsigned multiplier and presents each window sum on a valid/ready port.
// Optional feature macro: MULT_RESIDUE_CHECK_EN enables a mod-3 residue checker
// that flags beats whose product disagrees with its operands.
module mult4u_acc_stage #(
    parameter int ACC_LEN = 4,
    parameter int ACC_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [7:0]       in_p,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [4:0]       out_len,
    output logic             out_err,
    output logic [7:0]       err_cnt
);

    localparam int         MIN_W = 8 + $clog2(ACC_LEN + 1);
    localparam logic [4:0] LEN   = 5'(ACC_LEN);

    // Reject parameter sets that cannot hold a full window without overflow.
    generate
        if (ACC_LEN < 1 || ACC_LEN > 16) begin : g_bad_len
            $error("mult4u_acc_stage: ACC_LEN must be within 1..16");
        end
        if (ACC_W < MIN_W) begin : g_bad_w
            $error("mult4u_acc_stage: ACC_W too narrow for ACC_LEN");
        end
    endgenerate

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic [4:0]       cnt;
    logic             accept;
    logic             close;
    logic             release_win;
    logic [ACC_W-1:0] acc_inc;
    logic [4:0]       cnt_inc;

    // Handshake flags come straight from the state register, so no input
    // can reach them combinationally.
    assign in_ready    = (state == ACCUM);
    assign out_valid   = (state == HOLD);
    assign accept      = in_valid && in_ready;
    assign release_win = out_valid && out_ready;
    assign acc_inc     = acc + ACC_W'(in_p);
    assign cnt_inc     = cnt + 5'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    // Next-state logic: close on a full window or a flush that has something to
    // report (a stored beat or one arriving this cycle).
    always_comb begin
        state_nxt = state;
        close     = 1'b0;
        case (state)
            ACCUM: begin
                close = (accept && (cnt_inc == LEN)) ||
                        (flush && ((cnt != 5'd0) || accept));
                if (close) state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // Accumulator and result registers; the closing beat is folded into the
    // published sum/length on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            out_sum <= '0;
            out_len <= '0;
        end else begin
            if (release_win) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                acc <= acc_inc;
                cnt <= cnt_inc;
            end
            if (close) begin
                out_sum <= accept ? acc_inc : acc;
                out_len <= accept ? cnt_inc : cnt;
            end
        end
    end

`ifdef MULT_RESIDUE_CHECK_EN
    logic [1:0] res_a, res_b, res_p, res_ab;
    logic       beat_bad;
    logic       werr;

    // mod-3 residues: a product is consistent only if (a*b) mod 3 == p mod 3.
    assign res_a    = 2'(in_a % 4'd3);
    assign res_b    = 2'(in_b % 4'd3);
    assign res_p    = 2'(in_p % 8'd3);
    assign res_ab   = 2'(({2'b00, res_a} * {2'b00, res_b}) % 4'd3);
    assign beat_bad = accept && (res_ab != res_p);

    // Window error flag is sticky until the result is consumed; err_cnt is a
    // lifetime saturating count of bad beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            werr    <= 1'b0;
            out_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (release_win)   werr <= 1'b0;
            else if (beat_bad) werr <= 1'b1;
            if (close)         out_err <= werr || beat_bad;
            if (beat_bad && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    logic unused_operands;

    // Without the checker the operands carry no information for this stage.
    assign unused_operands = ^{in_a, in_b};
    assign out_err         = 1'b0;
    assign err_cnt         = '0;
`endif

endmodule

// File: tb/tb_mult4u_acc_stage.sv
// Self-checking bench for mult4u_acc_stage (ACC_LEN=4, ACC_W=12). A small
// window model pushes expected results to a scoreboard; a monitor pops them
// when the output handshake happens.
module tb_mult4u_acc_stage;

    localparam int ACC_LEN = 4;
    localparam int ACC_W   = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic [7:0]       in_p;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [4:0]       out_len;
    logic             out_err;
    logic [7:0]       err_cnt;

    typedef struct {
        int sum;
        int len;
        bit err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // model of the open window
    int m_acc = 0;
    int m_cnt = 0;
    bit m_err = 1'b0;
    int m_errcnt = 0;

    mult4u_acc_stage #(.ACC_LEN(ACC_LEN), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_p(in_p),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_len(out_len), .out_err(out_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit residue_bad(input int a, input int b, input int p);
`ifdef MULT_RESIDUE_CHECK_EN
        return (((a % 3) * (b % 3)) % 3) != (p % 3);
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard monitor: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output sum=%0d len=%0d (no result expected)", out_sum, out_len);
            end else begin
                e = sb.pop_front();
                if (out_sum !== ACC_W'(e.sum) || out_len !== 5'(e.len) || out_err !== e.err) begin
                    errors++;
                    $display("FAIL window_result got sum=%0d len=%0d err=%0b want sum=%0d len=%0d err=%0b",
                             out_sum, out_len, out_err, e.sum, e.len, e.err);
                end
            end
        end
    end

    function automatic void model_close();
        exp_t e;
        e.sum = m_acc; e.len = m_cnt; e.err = m_err;
        sb.push_back(e);
        m_acc = 0; m_cnt = 0; m_err = 1'b0;
    endfunction

    // One beat, waiting (bounded) for in_ready; fl raises flush with the beat.
    task automatic beat(input int a, input int b, input int p, input bit fl);
        int guard = 0;
        in_valid = 1'b1; in_a = 4'(a); in_b = 4'(b); in_p = 8'(p); flush = 1'b0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL beat_accept_timeout in_ready=%0b want 1", in_ready);
        end else begin
            flush = fl;
            m_acc += p; m_cnt++;
            if (residue_bad(a, b, p)) begin
                m_err = 1'b1;
                if (m_errcnt < 255) m_errcnt++;
            end
            if (m_cnt == ACC_LEN || fl) model_close();
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic flush_alone();
        flush = 1'b1;
        if (in_ready && m_cnt > 0) model_close();
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_p = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, out_sum, out_len, out_err, err_cnt} !== {1'b1, 1'b0, 12'd0, 5'd0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_state rdy=%0b vld=%0b sum=%0d len=%0d err=%0b cnt=%0d want 1 0 0 0 0 0",
                     in_ready, out_valid, out_sum, out_len, out_err, err_cnt);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(15, 15, 225, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 12'd900 || out_len !== 5'd4) begin
            errors++;
            $display("FAIL b2b_close vld=%0b rdy=%0b sum=%0d len=%0d want 1 0 900 4", out_valid, in_ready, out_sum, out_len);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_one_cycle vld=%0b rdy=%0b want 0 1", out_valid, in_ready);
        end
        for (int i = 0; i < 4; i++) beat(15, 15, 225, 1'b0);
        drain();
    endtask

    task automatic test_flush();
        beat(3, 5, 15, 1'b0);
        beat(2, 7, 14, 1'b0);
        flush_alone();
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 12'd29 || out_len !== 5'd2) begin
            errors++;
            $display("FAIL flush_close vld=%0b sum=%0d len=%0d want 1 29 2", out_valid, out_sum, out_len);
        end
        drain();
        flush_alone();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_flush vld=%0b rdy=%0b want 0 1", out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        beat(1, 1, 1, 1'b0); beat(2, 2, 4, 1'b0); beat(3, 3, 9, 1'b0); beat(4, 4, 16, 1'b0);
        in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9; in_p = 8'd81; flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 12'd30 || out_len !== 5'd4) begin
                errors++;
                $display("FAIL hold_stable cyc=%0d rdy=%0b vld=%0b sum=%0d len=%0d want 0 1 30 4",
                         i, in_ready, out_valid, out_sum, out_len);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL hold_release rdy=%0b vld=%0b pending=%0d want 1 0 0", in_ready, out_valid, sb.size());
        end
        beat(1, 1, 1, 1'b1);
        drain();
    endtask

    task automatic test_residue();
        beat(3, 5, 14, 1'b0);
        beat(1, 1, 1, 1'b1);
        drain();
        checks++;
        if (err_cnt !== 8'(m_errcnt)) begin
            errors++;
            $display("FAIL err_cnt_bad got %0d want %0d", err_cnt, m_errcnt);
        end
        beat(2, 2, 4, 1'b0);
        beat(2, 3, 6, 1'b1);
        drain();
        checks++;
        if (err_cnt !== 8'(m_errcnt)) begin
            errors++;
            $display("FAIL err_cnt_clean got %0d want %0d", err_cnt, m_errcnt);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) beat(1, 2, 2, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_acc = 0; m_cnt = 0; m_err = 1'b0; m_errcnt = 0;
        checks++;
        if ({in_ready, out_valid, out_sum, out_len, out_err, err_cnt} !== {1'b1, 1'b0, 12'd0, 5'd0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL mid_reset rdy=%0b vld=%0b sum=%0d len=%0d err=%0b cnt=%0d want 1 0 0 0 0 0",
                     in_ready, out_valid, out_sum, out_len, out_err, err_cnt);
        end
        for (int i = 0; i < 4; i++) beat(1, 2, 2, 1'b0);
        checks++;
        if (out_sum !== 12'd8 || out_len !== 5'd4) begin
            errors++;
            $display("FAIL post_reset_window sum=%0d len=%0d want 8 4", out_sum, out_len);
        end
        drain();
    endtask

    task automatic test_flush_with_beat();
        beat(1, 3, 3, 1'b0);
        beat(4, 4, 16, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 12'd19 || out_len !== 5'd2) begin
            errors++;
            $display("FAIL flush_with_beat vld=%0b sum=%0d len=%0d want 1 19 2", out_valid, out_sum, out_len);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_flush();
        test_hold();
        test_residue();
        test_mid_reset();
        test_flush_with_beat();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
